pipe_stage_buf: RTL and testbench

Parametrised pipeline-stage register that generalises the fixed inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) into one block. It carries a data bundle and a control bundle between stages with a valid/ready handshake, an optional two-entry skid buffer for registered backpressure, a flush path, and a saturating stall counter. Control bits read as zero whenever the stage holds no valid instruction, so downstream logic sees a NOP with RegWrite/MemWrite deasserted. It sits between any two CPU pipeline stages; cache-miss stalls arrive as `ready_i` low.

---
 rtl/pipe_pkg.sv | 30 +++
 rtl/sat_counter.sv | 34 +++
 rtl/pipe_stage_buf.sv | 144 ++++++++++++++
 tb/tb_pipe_stage_buf.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: occupancy states and inter-stage bundle widths.
// Imported by every pipeline-stage register and its helpers.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  localparam int IF_ID_DATA_W  = 64;
  localparam int IF_ID_CTRL_W  = 1;
  localparam int ID_EX_DATA_W  = 96;
  localparam int ID_EX_CTRL_W  = 17;
  localparam int EX_MEM_DATA_W = 69;
  localparam int EX_MEM_CTRL_W = 4;
  localparam int MEM_WB_DATA_W = 69;
  localparam int MEM_WB_CTRL_W = 2;

  typedef struct packed {
    logic [9:0] funct;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
  } id_ex_ctrl_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter, cleared only by reset.
// Shared by the pipeline stall and cache stall statistics.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en && inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Generic pipeline-stage register with valid/ready handshake,
// optional 2-entry skid buffer, flush and stall statistics.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 17,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic              acc;
  logic              xfer;

  assign valid_o = (state_q != ST_EMPTY);
  assign acc     = start_i & valid_i & ready_o & ~flush_i;
  assign xfer    = start_i & valid_o & ready_i;
  assign data_o  = main_data_q;
  // Bubbles must look like NOPs downstream.
  assign ctrl_o  = valid_o ? main_ctrl_q : '0;

  generate
    if (SKID != 0) begin : g_skid
      logic [DATA_W-1:0] skid_data_q, skid_data_d;
      logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;

      assign ready_o = (state_q != ST_TWO);

      always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        if (flush_i) begin
          state_d     = ST_EMPTY;
          main_data_d = '0;
          main_ctrl_d = '0;
          skid_data_d = '0;
          skid_ctrl_d = '0;
        end else begin
          unique case (state_q)
            ST_EMPTY: begin
              if (acc) begin
                state_d     = ST_ONE;
                main_data_d = data_i;
                main_ctrl_d = ctrl_i;
              end
            end
            ST_ONE: begin
              if (acc && xfer) begin
                main_data_d = data_i;
                main_ctrl_d = ctrl_i;
              end else if (acc) begin
                state_d     = ST_TWO;
                skid_data_d = data_i;
                skid_ctrl_d = ctrl_i;
              end else if (xfer) begin
                state_d = ST_EMPTY;
              end
            end
            ST_TWO: begin
              if (xfer) begin
                state_d     = ST_ONE;
                main_data_d = skid_data_q;
                main_ctrl_d = skid_ctrl_q;
              end
            end
            default: state_d = ST_EMPTY;
          endcase
        end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          skid_data_q <= '0;
          skid_ctrl_q <= '0;
        end else begin
          skid_data_q <= skid_data_d;
          skid_ctrl_q <= skid_ctrl_d;
        end
      end
    end else begin : g_single
      assign ready_o = ~valid_o | ready_i;

      always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        if (flush_i) begin
          state_d     = ST_EMPTY;
          main_data_d = '0;
          main_ctrl_d = '0;
        end else if (acc) begin
          state_d     = ST_ONE;
          main_data_d = data_i;
          main_ctrl_d = ctrl_i;
        end else if (xfer) begin
          state_d = ST_EMPTY;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .en    (start_i),
    .inc   (valid_o & ~ready_i),
    .cnt_o (stall_cnt_o)
  );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf: skid mode, single-entry mode,
// and a narrow stall counter for saturation and async reset.
module tb_pipe_stage_buf;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        a_start = 1'b1, a_flush = 1'b0, a_vin = 1'b0, a_rdy = 1'b0;
  logic [31:0] a_din = '0;
  logic [7:0]  a_cin = '0;
  logic        a_rdo, a_vo;
  logic [31:0] a_do;
  logic [7:0]  a_co;
  logic [15:0] a_cnt;

  logic        b_start = 1'b1, b_flush = 1'b0, b_vin = 1'b0, b_rdy = 1'b0;
  logic [31:0] b_din = '0;
  logic [7:0]  b_cin = '0;
  logic        b_rdo, b_vo;
  logic [31:0] b_do;
  logic [7:0]  b_co;
  logic [15:0] b_cnt;

  logic        c_start = 1'b1, c_flush = 1'b0, c_vin = 1'b0, c_rdy = 1'b0;
  logic [31:0] c_din = '0;
  logic [7:0]  c_cin = '0;
  logic        c_rdo, c_vo;
  logic [31:0] c_do;
  logic [7:0]  c_co;
  logic [3:0]  c_cnt;

  logic [39:0] q_a[$];
  logic [39:0] q_b[$];
  int          a_wait, b_wait;
  bit          b_done = 1'b0;

  pipe_stage_buf #(.DATA_W(32), .CTRL_W(8), .SKID(1), .CNT_W(16)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .start_i(a_start), .flush_i(a_flush),
    .valid_i(a_vin), .ready_o(a_rdo), .data_i(a_din), .ctrl_i(a_cin),
    .valid_o(a_vo), .ready_i(a_rdy), .data_o(a_do), .ctrl_o(a_co),
    .stall_cnt_o(a_cnt));

  pipe_stage_buf #(.DATA_W(32), .CTRL_W(8), .SKID(0), .CNT_W(16)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(b_start), .flush_i(b_flush),
    .valid_i(b_vin), .ready_o(b_rdo), .data_i(b_din), .ctrl_i(b_cin),
    .valid_o(b_vo), .ready_i(b_rdy), .data_o(b_do), .ctrl_o(b_co),
    .stall_cnt_o(b_cnt));

  pipe_stage_buf #(.DATA_W(32), .CTRL_W(8), .SKID(1), .CNT_W(4)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .start_i(c_start), .flush_i(c_flush),
    .valid_i(c_vin), .ready_o(c_rdo), .data_i(c_din), .ctrl_i(c_cin),
    .valid_o(c_vo), .ready_i(c_rdy), .data_o(c_do), .ctrl_o(c_co),
    .stall_cnt_o(c_cnt));

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ctl(input logic [31:0] d);
    return d[7:0] ^ 8'h5A;
  endfunction

  task automatic a_push(input logic [31:0] d);
    int n;
    n = 0;
    a_vin = 1'b1;
    a_din = d;
    a_cin = ctl(d);
    q_a.push_back({d, ctl(d)});
    @(negedge clk);
    while (!a_rdo && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL a_push_timeout: got no ready want ready");
    end
    a_wait = n;
    @(posedge clk);
    #1 a_vin = 1'b0;
  endtask

  task automatic b_push(input logic [31:0] d);
    int n;
    n = 0;
    b_vin = 1'b1;
    b_din = d;
    b_cin = ctl(d);
    q_b.push_back({d, ctl(d)});
    @(negedge clk);
    while (!b_rdo && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL b_push_timeout: got no ready want ready");
    end
    b_wait = n;
    @(posedge clk);
    #1 b_vin = 1'b0;
  endtask

  always @(negedge clk) begin
    logic [39:0] e;
    if (a_start && a_vo && a_rdy) begin
      if (q_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_extra: got %0h want nothing", a_do);
      end else begin
        e = q_a.pop_front();
        chk("a_order", {24'h0, a_do, a_co}, {24'h0, e});
      end
    end
    if (!a_vo) chk("a_nop_ctrl", a_co, 0);
    if (b_start && b_vo && b_rdy) begin
      if (q_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_extra: got %0h want nothing", b_do);
      end else begin
        e = q_b.pop_front();
        chk("b_order", {24'h0, b_do, b_co}, {24'h0, e});
      end
    end
    if (!b_vo) chk("b_nop_ctrl", b_co, 0);
  end

  initial begin
    #2;
    chk("rst_a_valid", a_vo, 0);
    chk("rst_a_data", a_do, 0);
    chk("rst_a_ctrl", a_co, 0);
    chk("rst_a_cnt", a_cnt, 0);
    chk("rst_a_ready", a_rdo, 1);
    chk("rst_b_ready", b_rdo, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Streaming at full rate through the skid stage.
    a_rdy = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      a_push(i);
      chk("a_stream_nowait", a_wait, 0);
      if (i == 1) begin
        chk("a_lat_valid", a_vo, 1);
        chk("a_lat_data", a_do, 1);
      end
    end
    chk("a_last_data", a_do, 8);
    chk("a_last_valid", a_vo, 1);
    @(posedge clk);
    #1;
    chk("a_drained", a_vo, 0);
    chk("a_stream_cnt", a_cnt, 0);
    chk("a_stream_q", q_a.size(), 0);

    // Three stalled cycles mid-stream.
    a_push(32'h11);
    fork
      begin
        a_push(32'h12);
        a_push(32'h13);
      end
      begin
        a_rdy = 1'b0;
        chk("a_rdy_one", a_rdo, 1);
        @(posedge clk);
        #1 chk("a_rdy_fall", a_rdo, 0);
        @(posedge clk);
        @(posedge clk);
        #1 a_rdy = 1'b1;
      end
    join
    @(posedge clk);
    #1;
    chk("a_stall_cnt", a_cnt, 3);
    chk("a_stall_q", q_a.size(), 0);
    chk("a_stall_drained", a_vo, 0);

    // Flush while two entries are held, with a word offered.
    a_rdy = 1'b0;
    a_push(32'h21);
    a_push(32'h22);
    chk("a_two_ready", a_rdo, 0);
    a_vin = 1'b1;
    a_din = 32'h23;
    a_cin = ctl(32'h23);
    a_flush = 1'b1;
    @(posedge clk);
    #1;
    a_flush = 1'b0;
    a_vin = 1'b0;
    q_a.delete();
    chk("a_flush_valid", a_vo, 0);
    chk("a_flush_ctrl", a_co, 0);
    chk("a_flush_data", a_do, 0);
    chk("a_flush_ready", a_rdo, 1);
    a_rdy = 1'b1;
    @(posedge clk);
    #1 chk("a_flush_noacc", a_vo, 0);

    // start_i low freezes everything.
    a_rdy = 1'b0;
    a_push(32'h31);
    a_start = 1'b0;
    a_vin = 1'b1;
    a_din = 32'h32;
    a_cin = ctl(32'h32);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("a_hold_valid", a_vo, 1);
      chk("a_hold_data", a_do, 32'h31);
      chk("a_hold_ctrl", a_co, ctl(32'h31));
      chk("a_hold_cnt", a_cnt, 5);
      chk("a_hold_ready", a_rdo, 1);
    end
    a_start = 1'b1;
    a_vin = 1'b0;
    a_rdy = 1'b1;
    @(posedge clk);
    #1;
    chk("a_hold_drained", a_vo, 0);
    chk("a_hold_cnt_after", a_cnt, 5);
    chk("a_hold_q", q_a.size(), 0);

    // Single-entry mode: full rate, then ready_i toggling.
    b_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b_push(32'h41 + i);
      chk("b_stream_nowait", b_wait, 0);
    end
    fork
      begin
        for (int i = 4; i < 12; i++) b_push(32'h41 + i);
        b_done = 1'b1;
      end
      begin
        while (!b_done) begin
          @(negedge clk);
          chk("b_rdy_neg", b_rdo, !b_vo || b_rdy);
          @(posedge clk);
          #1 b_rdy = ~b_rdy;
          #1 chk("b_rdy_comb", b_rdo, !b_vo || b_rdy);
        end
      end
    join
    b_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("b_toggle_q", q_b.size(), 0);
    chk("b_toggle_drained", b_vo, 0);

    // Narrow counter saturation, then async reset mid-stall.
    c_vin = 1'b1;
    c_din = 32'h51;
    c_cin = ctl(32'h51);
    @(posedge clk);
    #1 c_vin = 1'b0;
    repeat (10) @(posedge clk);
    #1 chk("c_cnt10", c_cnt, 10);
    repeat (10) @(posedge clk);
    #1 chk("c_cnt_sat", c_cnt, 15);
    chk("c_held_data", c_do, 32'h51);
    #2 rst_n = 1'b0;
    #1;
    chk("c_rst_valid", c_vo, 0);
    chk("c_rst_data", c_do, 0);
    chk("c_rst_ctrl", c_co, 0);
    chk("c_rst_cnt", c_cnt, 0);
    chk("c_rst_ready", c_rdo, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("c_post_rst_valid", c_vo, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
